// File: rtl/mult_stage_pkg.sv
// Shared types and sizing for the PE multiply stage: control bundle, mode/state enums
// and the slice-count saturation helper.
package mult_stage_pkg;
  localparam int DWD     = 16;
  localparam int PSUMDWD = 32;
  localparam int PEROW   = 4;
  localparam int SLW     = 4;
  localparam int NSL     = DWD / SLW;
  localparam int SIW     = $clog2(NSL);
  localparam int NTW     = 3;

  typedef enum logic [2:0] {XNOR = 3'd0, P1, P2, P3, P4} ms_mode_e;
  typedef enum logic [1:0] {MS_IDLE, MS_CALC, MS_HOLD} ms_fsm_e;

  typedef struct packed {
    logic [3:0] ssctl;
    logic [3:0] ssppctl;
  } ms_out_ctl_t;

  typedef struct packed {
    logic [2:0]     mode;
    logic [NTW-1:0] inumt;
    logic [NTW-1:0] wnumt;
    logic [DWD-1:0] au_mask;
    ms_out_ctl_t    pass;
  } ms_ctl_t;

  // Zero means one slice; anything beyond the operand width saturates.
  function automatic logic [NTW-1:0] eff_numt(input logic [NTW-1:0] n);
    if (n == '0) return NTW'(1);
    if (n > NTW'(NSL)) return NTW'(NSL);
    return n;
  endfunction
endpackage

// File: rtl/mult_slice_lane.sv
// One PE row: SLW x SLW slice multiply with per-slice sign select, shifted accumulate,
// and the single-cycle XNOR/popcount dot loaded at accept.
module mult_slice_lane
  import mult_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue,
  input  logic               clr,
  input  logic               ld_xnor,
  input  logic [SIW-1:0]     ii,
  input  logic [SIW-1:0]     jj,
  input  logic [NTW-1:0]     inumt,
  input  logic [NTW-1:0]     wnumt,
  input  logic [DWD-1:0]     op_in,
  input  logic [DWD-1:0]     op_w,
  input  logic [DWD-1:0]     x_in,
  input  logic [DWD-1:0]     x_w,
  input  logic [DWD-1:0]     x_mask,
  output logic [PSUMDWD-1:0] acc
);
  logic [SLW-1:0]          si, sw;
  logic signed [SLW:0]     ai, aw;
  logic signed [2*SLW+1:0] p;
  logic [SIW:0]            sh;
  logic [PSUMDWD-1:0]      term, xv;

  // Only the top slice carries the sign; lower slices extend with zero.
  always_comb begin
    si   = op_in[SLW*ii +: SLW];
    sw   = op_w[SLW*jj +: SLW];
    ai   = {(NTW'(ii) == inumt - 1'b1) & si[SLW-1], si};
    aw   = {(NTW'(jj) == wnumt - 1'b1) & sw[SLW-1], sw};
    p    = ai * aw;
    sh   = {1'b0, ii} + {1'b0, jj};
    term = {{(PSUMDWD-2*SLW-2){p[2*SLW+1]}}, p} << (SLW*sh);
  end

  assign xv = PSUMDWD'(2*$countones(~(x_in ^ x_w) & x_mask) - $countones(x_mask));

  always_ff @(posedge clk) begin
    if (rst)          acc <= '0;
    else if (clr)     acc <= '0;
    else if (ld_xnor) acc <= xv;
    else if (issue)   acc <= acc + term;
  end
endmodule

// File: rtl/mult_stage.sv
// PE multiply stage: accepts one transaction, iterates slice pairs (or one-shot XNOR),
// then holds the result until the sum stage acknowledges.
module mult_stage
  import mult_stage_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            FS_rdy,
  output logic                            FS_ack,
  input  ms_ctl_t                         i_ctl,
  input  logic [PEROW-1:0][DWD-1:0]       i_input,
  input  logic [PEROW-1:0][DWD-1:0]       i_weight,
  input  logic [PEROW-1:0][PSUMDWD-1:0]   i_psum,
  output logic                            MS_rdy,
  input  logic                            MS_ack,
  output logic [PEROW-1:0][PSUMDWD-1:0]   o_prod,
  output logic [PEROW-1:0][PSUMDWD-1:0]   o_psum,
  output ms_out_ctl_t                     o_ctl
);
  ms_fsm_e                   state;
  logic [SIW-1:0]            ii, jj;
  logic [NTW-1:0]            inumt, wnumt;
  logic [PEROW-1:0][DWD-1:0] in_q, w_q;
  logic                      accept, is_x, is_off, issue, last_i, last_j;

  assign FS_ack = FS_rdy && (state == MS_IDLE);
  assign accept = FS_ack;
  assign is_x   = i_ctl.mode == XNOR;
  assign is_off = i_ctl.mode > P4;
  assign issue  = state == MS_CALC;
  assign last_i = NTW'(ii) == inumt - 1'b1;
  assign last_j = NTW'(jj) == wnumt - 1'b1;
  assign MS_rdy = state == MS_HOLD;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= MS_IDLE;
      ii     <= '0;
      jj     <= '0;
      inumt  <= '0;
      wnumt  <= '0;
      in_q   <= '0;
      w_q    <= '0;
      o_psum <= '0;
      o_ctl  <= '0;
    end else begin
      case (state)
        MS_IDLE: if (accept) begin
          in_q   <= i_input;
          w_q    <= i_weight;
          o_psum <= i_psum;
          o_ctl  <= i_ctl.pass;
          inumt  <= eff_numt(i_ctl.inumt);
          wnumt  <= eff_numt(i_ctl.wnumt);
          ii     <= '0;
          jj     <= '0;
          // Disabled modes (>P4) finish immediately with a cleared product.
          state  <= (is_x || is_off) ? MS_HOLD : MS_CALC;
        end
        MS_CALC: begin
          if (last_j) begin
            jj <= '0;
            if (last_i) begin
              ii    <= '0;
              state <= MS_HOLD;
            end else begin
              ii <= ii + 1'b1;
            end
          end else begin
            jj <= jj + 1'b1;
          end
        end
        MS_HOLD: if (MS_ack) state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < PEROW; r++) begin : g_lane
    mult_slice_lane u_lane (
      .clk     (i_clk),
      .rst     (i_rst),
      .issue   (issue),
      .clr     (accept && !is_x),
      .ld_xnor (accept && is_x),
      .ii      (ii),
      .jj      (jj),
      .inumt   (inumt),
      .wnumt   (wnumt),
      .op_in   (in_q[r]),
      .op_w    (w_q[r]),
      .x_in    (i_input[r]),
      .x_w     (i_weight[r]),
      .x_mask  (i_ctl.au_mask),
      .acc     (o_prod[r])
    );
  end
endmodule

// File: tb/tb_mult_stage.sv
// Scoreboard bench for mult_stage: expected results are queued at issue and compared
// (product, psum, ctl, latency) when MS_rdy rises.
module tb_mult_stage;
  import mult_stage_pkg::*;

  logic                          i_clk = 1'b0;
  logic                          i_rst, FS_rdy, FS_ack, MS_rdy, MS_ack;
  ms_ctl_t                       i_ctl;
  ms_out_ctl_t                   o_ctl;
  logic [PEROW-1:0][DWD-1:0]     i_input, i_weight;
  logic [PEROW-1:0][PSUMDWD-1:0] i_psum, o_prod, o_psum;

  typedef struct {
    logic [PEROW-1:0][PSUMDWD-1:0] prod;
    logic [PEROW-1:0][PSUMDWD-1:0] psum;
    ms_out_ctl_t                   ctl;
    int                            lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mult_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .FS_rdy(FS_rdy), .FS_ack(FS_ack), .i_ctl(i_ctl),
    .i_input(i_input), .i_weight(i_weight), .i_psum(i_psum), .MS_rdy(MS_rdy),
    .MS_ack(MS_ack), .o_prod(o_prod), .o_psum(o_psum), .o_ctl(o_ctl)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int nt(input logic [2:0] n);
    if (n == 3'd0) return 1;
    if (n > 3'd4) return 4;
    return int'(n);
  endfunction

  function automatic logic [PSUMDWD-1:0] ref_prod(input ms_ctl_t c, input logic [DWD-1:0] a, w);
    int     ni, nw, pc, pm;
    longint sa, sw;
    if (c.mode == 3'd0) begin
      pc = 0; pm = 0;
      for (int b = 0; b < DWD; b++)
        if (c.au_mask[b]) begin
          pm++;
          if (a[b] == w[b]) pc++;
        end
      return PSUMDWD'(2*pc - pm);
    end
    if (c.mode > 3'd4) return '0;
    ni = nt(c.inumt);
    nw = nt(c.wnumt);
    sa = longint'(a) & ((longint'(1) << (4*ni)) - 1);
    sw = longint'(w) & ((longint'(1) << (4*nw)) - 1);
    if (((sa >> (4*ni-1)) & 1) != 0) sa = sa - (longint'(1) << (4*ni));
    if (((sw >> (4*nw-1)) & 1) != 0) sw = sw - (longint'(1) << (4*nw));
    return PSUMDWD'(sa * sw);
  endfunction

  function automatic exp_t mk_exp(input ms_ctl_t c, input logic [PEROW-1:0][DWD-1:0] a, w,
                                  input logic [PEROW-1:0][PSUMDWD-1:0] ps);
    exp_t e;
    for (int r = 0; r < PEROW; r++) e.prod[r] = ref_prod(c, a[r], w[r]);
    e.psum = ps;
    e.ctl  = c.pass;
    e.lat  = (c.mode == 3'd0 || c.mode > 3'd4) ? 1 : nt(c.inumt) * nt(c.wnumt) + 1;
    return e;
  endfunction

  function automatic ms_ctl_t rnd_ctl();
    ms_ctl_t c;
    c.mode    = 3'($urandom_range(0, 7));
    c.inumt   = 3'($urandom_range(0, 7));
    c.wnumt   = 3'($urandom_range(0, 7));
    c.au_mask = 16'($urandom);
    c.pass    = 8'($urandom);
    return c;
  endfunction

  function automatic logic [PEROW-1:0][DWD-1:0] rnd_ops();
    logic [PEROW-1:0][DWD-1:0] v;
    for (int r = 0; r < PEROW; r++) v[r] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [PEROW-1:0][PSUMDWD-1:0] rnd_psum();
    logic [PEROW-1:0][PSUMDWD-1:0] v;
    for (int r = 0; r < PEROW; r++) v[r] = $urandom;
    return v;
  endfunction

  // Present one transaction and return just after its accept edge; inputs are then scrambled.
  task automatic send(input ms_ctl_t c, input logic [PEROW-1:0][DWD-1:0] a, w,
                      input logic [PEROW-1:0][PSUMDWD-1:0] ps, input bit push);
    int n;
    if (push) sb.push_back(mk_exp(c, a, w, ps));
    i_ctl = c; i_input = a; i_weight = w; i_psum = ps; FS_rdy = 1'b1;
    #1;
    n = 0;
    while (!FS_ack && n < 30) begin step(); n++; end
    if (!FS_ack) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout FS_ack=%b required 1", FS_ack);
    end
    step();
    FS_rdy = 1'b0; i_ctl = rnd_ctl(); i_input = rnd_ops(); i_weight = rnd_ops(); i_psum = rnd_psum();
  endtask

  task automatic recv(input int ack_delay);
    exp_t e;
    int   cnt;
    cnt = 1;
    while (!MS_rdy && cnt < 40) begin step(); cnt++; end
    e = sb.pop_front();
    n_vec++;
    if (!MS_rdy || cnt != e.lat) begin
      n_err++;
      $display("FAIL latency got %0d (rdy=%b) want %0d", cnt, MS_rdy, e.lat);
    end
    for (int r = 0; r < PEROW; r++) begin
      n_vec++;
      if (o_prod[r] !== e.prod[r]) begin
        n_err++;
        $display("FAIL prod row%0d got %h want %h", r, o_prod[r], e.prod[r]);
      end
    end
    n_vec++;
    if (o_psum !== e.psum) begin
      n_err++;
      $display("FAIL psum got %h want %h", o_psum, e.psum);
    end
    n_vec++;
    if (o_ctl !== e.ctl) begin
      n_err++;
      $display("FAIL ctl got %h want %h", o_ctl, e.ctl);
    end
    repeat (ack_delay) step();
    MS_ack = 1'b1;
    step();
    MS_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; FS_rdy = 1'b1; MS_ack = 1'b0;
    i_ctl = '0; i_input = '0; i_weight = '0; i_psum = '0;
    repeat (3) step();
    n_vec++;
    if (MS_rdy !== 1'b0 || o_prod !== '0 || o_psum !== '0 || o_ctl !== '0) begin
      n_err++;
      $display("FAIL reset_state rdy=%b prod=%h psum=%h ctl=%h want all 0", MS_rdy, o_prod, o_psum, o_ctl);
    end
    n_vec++;
    if (FS_ack !== 1'b1) begin
      n_err++;
      $display("FAIL reset_fs_ack got %b want 1", FS_ack);
    end
    i_rst = 1'b0; FS_rdy = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_calc();
    ms_ctl_t c;
    bit      seen;
    c = rnd_ctl(); c.mode = 3'd4; c.inumt = 3'd4; c.wnumt = 3'd4;
    send(c, rnd_ops(), rnd_ops(), rnd_psum(), 1'b0);
    step(); step();
    i_rst = 1'b1; FS_rdy = 1'b1;
    step();
    i_rst = 1'b0;
    n_vec++;
    if (MS_rdy !== 1'b0 || o_prod !== '0 || o_psum !== '0) begin
      n_err++;
      $display("FAIL midcalc_reset rdy=%b prod=%h psum=%h want 0", MS_rdy, o_prod, o_psum);
    end
    n_vec++;
    if (FS_ack !== 1'b1) begin
      n_err++;
      $display("FAIL midcalc_fs_ack got %b want 1", FS_ack);
    end
    FS_rdy = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      step();
      if (MS_rdy) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL midcalc_abort MS_rdy seen=1 want 0");
    end
  endtask

  task automatic test_signed16();
    ms_ctl_t c;
    logic [PEROW-1:0][DWD-1:0] a, w;
    c = rnd_ctl(); c.mode = 3'd4; c.inumt = 3'd4; c.wnumt = 3'd4;
    a = rnd_ops(); w = rnd_ops(); a[0] = 16'hFFFE; w[0] = 16'h0003;
    send(c, a, w, rnd_psum(), 1'b1);
    recv(0);
    n_vec++;
    if (o_prod[0] !== 32'hFFFF_FFFA) begin
      n_err++;
      $display("FAIL signed16_const got %h want FFFFFFFA", o_prod[0]);
    end
  endtask

  task automatic test_mixed();
    ms_ctl_t c;
    logic [PEROW-1:0][DWD-1:0] a, w;
    c = rnd_ctl(); c.mode = 3'd2; c.inumt = 3'd1; c.wnumt = 3'd2;
    a = rnd_ops(); w = rnd_ops(); a[0] = 16'hA5F9; w[0] = 16'h127F;
    send(c, a, w, rnd_psum(), 1'b1);
    recv(1);
    n_vec++;
    if (o_prod[0] !== 32'hFFFF_FC87) begin
      n_err++;
      $display("FAIL mixed_const got %h want FFFFFC87", o_prod[0]);
    end
  endtask

  task automatic test_xnor();
    ms_ctl_t c;
    logic [PEROW-1:0][DWD-1:0] a, w;
    logic [15:0] masks [2];
    logic [31:0] want [2];
    masks[0] = 16'h00FF; masks[1] = 16'hFFFF;
    want[0]  = 32'd8;    want[1]  = 32'd0;
    for (int k = 0; k < 2; k++) begin
      c = rnd_ctl(); c.mode = 3'd0; c.au_mask = masks[k];
      a = rnd_ops(); w = rnd_ops(); a[0] = 16'hFFFF; w[0] = 16'h00FF;
      send(c, a, w, rnd_psum(), 1'b1);
      recv(0);
      n_vec++;
      if (o_prod[0] !== want[k]) begin
        n_err++;
        $display("FAIL xnor_const%0d got %h want %h", k, o_prod[0], want[k]);
      end
    end
    c = rnd_ctl(); c.mode = 3'd6;
    send(c, rnd_ops(), rnd_ops(), rnd_psum(), 1'b1);
    recv(0);
  endtask

  task automatic test_backpressure();
    ms_ctl_t c, cb;
    exp_t    e;
    logic [PEROW-1:0][PSUMDWD-1:0] sp, ss;
    ms_out_ctl_t sc;
    logic [PEROW-1:0][DWD-1:0] ba, bw;
    logic [PEROW-1:0][PSUMDWD-1:0] bp;
    int n;
    bit bad;
    c = rnd_ctl(); c.mode = 3'd2; c.inumt = 3'd2; c.wnumt = 3'd2;
    send(c, rnd_ops(), rnd_ops(), rnd_psum(), 1'b1);
    n = 0;
    while (!MS_rdy && n < 40) begin step(); n++; end
    e = sb.pop_front();
    sp = o_prod; ss = o_psum; sc = o_ctl;
    n_vec++;
    if (!MS_rdy || sp !== e.prod || ss !== e.psum || sc !== e.ctl) begin
      n_err++;
      $display("FAIL bp_first rdy=%b prod=%h psum=%h ctl=%h want prod=%h psum=%h ctl=%h",
               MS_rdy, sp, ss, sc, e.prod, e.psum, e.ctl);
    end
    cb = rnd_ctl(); cb.mode = 3'd3; ba = rnd_ops(); bw = rnd_ops(); bp = rnd_psum();
    i_ctl = cb; i_input = ba; i_weight = bw; i_psum = bp; FS_rdy = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (FS_ack !== 1'b0 || MS_rdy !== 1'b1 || o_prod !== sp || o_psum !== ss || o_ctl !== sc) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL bp_hold FS_ack=%b MS_rdy=%b outputs changed, want FS_ack=0 MS_rdy=1 stable", FS_ack, MS_rdy);
    end
    sb.push_back(mk_exp(cb, ba, bw, bp));
    MS_ack = 1'b1;
    step();
    MS_ack = 1'b0;
    n_vec++;
    if (FS_ack !== 1'b1 || MS_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release FS_ack=%b MS_rdy=%b want 1 0", FS_ack, MS_rdy);
    end
    step();
    FS_rdy = 1'b0;
    recv(0);
  endtask

  task automatic test_clamp();
    ms_ctl_t c;
    c = rnd_ctl(); c.mode = 3'd3; c.inumt = 3'd0; c.wnumt = 3'd7;
    send(c, rnd_ops(), rnd_ops(), rnd_psum(), 1'b1);
    recv(0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      send(rnd_ctl(), rnd_ops(), rnd_ops(), rnd_psum(), 1'b1);
      recv($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_calc();
    test_signed16();
    test_mixed();
    test_xnor();
    test_backpressure();
    test_clamp();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
